// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample word width, buffer control states and
// default sizing constants also used by the op encoder.
package audio_pkg;

    localparam int unsigned SAMPLE_W      = 32;
    localparam int unsigned DEF_DEPTH     = 8;
    localparam int unsigned DEF_BURST     = 4;
    localparam int unsigned DEF_LOW_WATER = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; flush empties it in one cycle.
// Push when full and pop when empty are ignored.
module sync_fifo
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned W     = SAMPLE_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        level   = wr_ptr - rd_ptr;
        full    = (level == (AW+1)'(DEPTH));
        empty   = (level == '0);
        do_push = push && !full && !flush;
        do_pop  = pop && !empty && !flush;
        dout    = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/audio_sample_buffer.sv
// Elastic stereo sample buffer between the op decoder and the I2S sender:
// primes before playback, mutes on underrun and paces host sample requests.
module audio_sample_buffer
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned START_LEVEL = 4,
    parameter int unsigned LOW_WATER   = DEF_LOW_WATER,
    parameter int unsigned BURST       = DEF_BURST,
    parameter int unsigned REQ_GAP     = 64
) (
    input  logic                   mon_clk,
    input  logic                   rst_n,
    input  logic                   audio_start,
    input  logic                   audio_stop,
    input  logic                   wr_valid,
    input  logic [SAMPLE_W-1:0]    wr_data,
    input  logic                   rd_strobe,
    output logic [SAMPLE_W-1:0]    rd_data,
    output logic                   rd_data_valid,
    output logic                   audio_req,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             underrun_cnt,
    output logic                   overflow
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned GW = $clog2(REQ_GAP + 1);
    localparam logic [LW:0]   LOW_THR   = (LW+1)'(LOW_WATER);
    localparam logic [LW-1:0] START_THR = LW'(START_LEVEL);
    localparam logic [LW-1:0] PEND_MAX  = LW'(DEPTH);
    localparam logic [LW-1:0] PEND_ADD  = LW'(BURST);
    localparam logic [LW-1:0] PEND_SAT  = LW'(DEPTH - BURST);
    localparam logic [GW-1:0] GAP_INIT  = GW'(REQ_GAP);

    state_t                state;
    state_t                state_nx;
    logic                  ctrl;
    logic                  active;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  req_fire;
    logic                  underrun;
    logic [SAMPLE_W-1:0]   fifo_dout;
    logic [LW-1:0]         pending;
    logic [LW-1:0]         pend_dec;
    logic [LW-1:0]         pending_nx;
    logic [GW-1:0]         gap;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (SAMPLE_W)
    ) u_fifo (
        .clk   (mon_clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (ctrl),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        state_nx   = state;
        ctrl       = audio_start || audio_stop;
        active     = (state != ST_IDLE);
        push       = !ctrl && active && wr_valid && !full;
        pop        = !ctrl && rd_strobe && (state == ST_PLAY) && !empty;
        underrun   = !ctrl && rd_strobe && (state == ST_PLAY) && empty;
        req_fire   = !ctrl && active && (gap == '0) &&
                     (({1'b0, level} + {1'b0, pending}) <= LOW_THR);
        // dropped writes still consume an outstanding request slot
        pend_dec   = (wr_valid && pending != '0) ? pending - 1'b1 : pending;
        pending_nx = pend_dec;
        if (req_fire)
            pending_nx = (pend_dec > PEND_SAT) ? PEND_MAX : pend_dec + PEND_ADD;

        if (audio_stop) begin
            state_nx = ST_IDLE;
        end else if (audio_start) begin
            state_nx = ST_PRIME;
        end else begin
            unique case (state)
                ST_IDLE:  state_nx = ST_IDLE;
                ST_PRIME: if (level >= START_THR) state_nx = ST_PLAY;
                ST_PLAY:  if (underrun) state_nx = ST_PRIME;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge mon_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            audio_req     <= 1'b0;
            pending       <= '0;
            gap           <= '0;
            underrun_cnt  <= '0;
            overflow      <= 1'b0;
        end else begin
            state <= state_nx;

            if (audio_start && !audio_stop) gap <= '0;
            else if (req_fire)              gap <= GAP_INIT;
            else if (gap != '0)             gap <= gap - 1'b1;

            if (ctrl) begin
                audio_req     <= 1'b0;
                pending       <= '0;
                rd_data       <= '0;
                rd_data_valid <= 1'b0;
                if (!audio_stop) begin
                    overflow     <= 1'b0;
                    underrun_cnt <= '0;
                end
            end else begin
                audio_req <= req_fire;
                pending   <= pending_nx;
                if (active && wr_valid && full) overflow <= 1'b1;
                if (rd_strobe) begin
                    rd_data       <= pop ? fifo_dout : '0;
                    rd_data_valid <= pop;
                end
                if (underrun && underrun_cnt != 8'hFF)
                    underrun_cnt <= underrun_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Bench for audio_sample_buffer: directed vector table, corner-case sequences
// and random traffic, all checked against a queue-based reference model.
module tb_audio_sample_buffer;

    localparam int DEPTH       = 8;
    localparam int START_LEVEL = 4;
    localparam int LOW_WATER   = 4;
    localparam int BURST       = 4;
    localparam int REQ_GAP     = 64;

    logic        mon_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        audio_start = 1'b0;
    logic        audio_stop = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        rd_strobe = 1'b0;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        audio_req;
    logic [3:0]  level;
    logic [7:0]  underrun_cnt;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    audio_sample_buffer #(
        .DEPTH       (DEPTH),
        .START_LEVEL (START_LEVEL),
        .LOW_WATER   (LOW_WATER),
        .BURST       (BURST),
        .REQ_GAP     (REQ_GAP)
    ) dut (
        .mon_clk       (mon_clk),
        .rst_n         (rst_n),
        .audio_start   (audio_start),
        .audio_stop    (audio_stop),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .rd_strobe     (rd_strobe),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .audio_req     (audio_req),
        .level         (level),
        .underrun_cnt  (underrun_cnt),
        .overflow      (overflow)
    );

    always #5 mon_clk = ~mon_clk;

    // reference model: queue of stored words plus the observable registers
    logic [31:0] q[$];
    int          m_pend, m_gap, m_under;
    bit          m_active, m_play, m_req, m_val, m_ovf;
    logic [31:0] m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pend = 0; m_gap = 0; m_under = 0;
        m_active = 0; m_play = 0; m_req = 0; m_val = 0; m_ovf = 0;
        m_rd = '0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit wr,
                              input logic [31:0] d, input bit rd);
        int lvl;
        bit req_now;
        lvl     = q.size();
        req_now = !st && !sp && m_active && (m_gap == 0) && (lvl + m_pend <= LOW_WATER);
        if (st && !sp)    m_gap = 0;
        else if (req_now) m_gap = REQ_GAP;
        else if (m_gap > 0) m_gap--;
        if (sp || st) begin
            q.delete();
            m_active = !sp;
            m_play = 0; m_pend = 0; m_req = 0; m_rd = '0; m_val = 0;
            if (!sp) begin m_ovf = 0; m_under = 0; end
        end else begin
            m_req = req_now;
            if (rd) begin
                if (m_play && lvl > 0) begin
                    m_rd = q.pop_front(); m_val = 1;
                end else begin
                    m_rd = '0; m_val = 0;
                    if (m_play && m_under < 255) m_under++;
                end
            end
            if (wr && m_active) begin
                if (lvl < DEPTH) q.push_back(d);
                else m_ovf = 1;
            end
            if (wr && m_pend > 0) m_pend--;
            if (req_now) m_pend = (m_pend + BURST > DEPTH) ? DEPTH : m_pend + BURST;
            if (m_play && rd && lvl == 0)                         m_play = 0;
            else if (m_active && !m_play && lvl >= START_LEVEL)   m_play = 1;
        end
    endtask

    task automatic check_model();
        chk("model_level",    32'(level),         32'(q.size()));
        chk("model_rd_data",  rd_data,            m_rd);
        chk("model_valid",    32'(rd_data_valid), 32'(m_val));
        chk("model_req",      32'(audio_req),     32'(m_req));
        chk("model_underrun", 32'(underrun_cnt),  32'(m_under));
        chk("model_overflow", 32'(overflow),      32'(m_ovf));
    endtask

    task automatic step(input bit st, input bit sp, input bit wr,
                        input logic [31:0] d, input bit rd);
        audio_start = st; audio_stop = sp; wr_valid = wr; wr_data = d; rd_strobe = rd;
        @(posedge mon_clk);
        #1;
        model_step(st, sp, wr, d, rd);
        check_model();
        audio_start = 0; audio_stop = 0; wr_valid = 0; wr_data = '0; rd_strobe = 0;
    endtask

    task automatic nop();  step(0, 0, 0, '0, 0); endtask
    task automatic wr(input logic [31:0] d); step(0, 0, 1, d, 0); endtask
    task automatic rd();   step(0, 0, 0, '0, 1); endtask
    task automatic start(); step(1, 0, 0, '0, 0); endtask

    typedef struct {
        bit          st, sp, wr;
        logic [31:0] d;
        bit          rd;
        logic [31:0] e_data;
        bit          e_val, e_req;
        int          e_lvl, e_under;
    } vec_t;

    vec_t tbl[14];
    int   req_idx[$];

    initial begin
        tbl[0]  = '{1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 0};
        tbl[2]  = '{0, 0, 1, 32'h00010002, 0, 32'h0,        0, 0, 1, 0};
        tbl[3]  = '{0, 0, 1, 32'h00020003, 0, 32'h0,        0, 0, 2, 0};
        tbl[4]  = '{0, 0, 1, 32'h00030004, 0, 32'h0,        0, 0, 3, 0};
        tbl[5]  = '{0, 0, 1, 32'h00040005, 0, 32'h0,        0, 0, 4, 0};
        tbl[6]  = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 4, 0};
        tbl[7]  = '{0, 0, 0, 32'h0,        1, 32'h00010002, 1, 0, 3, 0};
        tbl[8]  = '{0, 0, 0, 32'h0,        1, 32'h00020003, 1, 0, 2, 0};
        tbl[9]  = '{0, 0, 0, 32'h0,        1, 32'h00030004, 1, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 32'h0,        1, 32'h00040005, 1, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 32'h0,        0, 32'h00040005, 1, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 0, 1};
        tbl[13] = '{0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 0, 1};

        model_reset();
        repeat (2) @(posedge mon_clk);
        #1;
        chk("reset_rd_data",  rd_data, 32'h0);
        chk("reset_valid",    32'(rd_data_valid), 32'h0);
        chk("reset_req",      32'(audio_req), 32'h0);
        chk("reset_level",    32'(level), 32'h0);
        chk("reset_underrun", 32'(underrun_cnt), 32'h0);
        chk("reset_overflow", 32'(overflow), 32'h0);
        rst_n = 1'b1;

        // directed vector table: priming, in-order playback, underrun
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].st, tbl[i].sp, tbl[i].wr, tbl[i].d, tbl[i].rd);
            chk($sformatf("vec%0d_data", i),     rd_data, tbl[i].e_data);
            chk($sformatf("vec%0d_valid", i),    32'(rd_data_valid), 32'(tbl[i].e_val));
            chk($sformatf("vec%0d_req", i),      32'(audio_req), 32'(tbl[i].e_req));
            chk($sformatf("vec%0d_level", i),    32'(level), 32'(tbl[i].e_lvl));
            chk($sformatf("vec%0d_underrun", i), 32'(underrun_cnt), 32'(tbl[i].e_under));
        end

        // request pacing with no writes: pulses one cycle after start and again after the gap
        start();
        for (int i = 1; i <= 150; i++) begin
            nop();
            if (audio_req) req_idx.push_back(i);
        end
        chk("req_count", 32'(req_idx.size()), 32'd2);
        if (req_idx.size() == 2) begin
            chk("req_first_cycle",  32'(req_idx[0]), 32'd1);
            chk("req_second_cycle", 32'(req_idx[1]), 32'(1 + REQ_GAP + 1));
        end

        // underrun counter saturation
        start();
        for (int n = 0; n < 256; n++) begin
            for (int k = 0; k < 4; k++) wr(32'(n * 4 + k));
            nop();
            repeat (5) rd();
        end
        chk("underrun_saturated", 32'(underrun_cnt), 32'd255);

        // overflow on the ninth write, cleared by start
        start();
        for (int k = 0; k < 9; k++) wr(32'hA000_0000 + 32'(k));
        chk("overflow_set",  32'(overflow), 32'd1);
        chk("overflow_lvl",  32'(level), 32'd8);
        start();
        chk("overflow_clr",  32'(overflow), 32'd0);
        chk("overflow_lvl0", 32'(level), 32'd0);

        // simultaneous push and pop, then on empty
        start();
        for (int k = 0; k < 4; k++) wr(32'hB000_0000 + 32'(k));
        nop(); rd(); rd();
        step(0, 0, 1, 32'hB000_0004, 1);
        chk("pushpop_level", 32'(level), 32'd2);
        chk("pushpop_data",  rd_data, 32'hB000_0002);
        rd(); rd();
        chk("drain_data",    rd_data, 32'hB000_0004);
        step(0, 0, 1, 32'hB000_0005, 1);
        chk("empty_pp_valid", 32'(rd_data_valid), 32'd0);
        chk("empty_pp_under", 32'(underrun_cnt), 32'd1);
        chk("empty_pp_level", 32'(level), 32'd1);

        // start and stop together mid-play, then asynchronous reset
        start();
        for (int k = 0; k < 4; k++) wr(32'hC000_0000 + 32'(k));
        nop(); rd();
        step(1, 1, 0, '0, 0);
        chk("startstop_level", 32'(level), 32'd0);
        req_idx.delete();
        for (int i = 0; i < 100; i++) begin
            step(0, 0, (i % 3) == 0, 32'(i), (i % 2) == 0);
            if (audio_req) req_idx.push_back(i);
        end
        chk("idle_no_req", 32'(req_idx.size()), 32'd0);
        start();
        for (int k = 0; k < 4; k++) wr(32'hD000_0000 + 32'(k));
        nop(); rd();
        chk("pre_reset_valid", 32'(rd_data_valid), 32'd1);
        @(negedge mon_clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_rd_data", rd_data, 32'h0);
        chk("areset_valid",   32'(rd_data_valid), 32'h0);
        chk("areset_req",     32'(audio_req), 32'h0);
        chk("areset_level",   32'(level), 32'h0);
        chk("areset_under",   32'(underrun_cnt), 32'h0);
        @(posedge mon_clk);
        #1;
        rst_n = 1'b1;

        // random traffic against the model
        start();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 99) < 45, $urandom(), $urandom_range(0, 99) < 35);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
